// File: rtl/toysram_scan_ctl_if.sv
// Pad-side scan signals, status/config words and frame status of the scan controller.
// The slave modport is the controller's view of these signals.
interface toysram_scan_ctl_if #(
  parameter int unsigned W = 128
);
  logic                 te_i;
  logic                 scan_clk_i;
  logic                 scan_di_i;
  logic                 scan_do_o;
  logic [W-1:0]         status_i;
  logic [W-1:0]         cfg_o;
  logic                 cfg_upd_o;
  logic [$clog2(W)-1:0] shift_cnt_o;
  logic                 frame_o;
  logic                 busy_o;

  modport slave (
    input  te_i,
    input  scan_clk_i,
    input  scan_di_i,
    input  status_i,
    output scan_do_o,
    output cfg_o,
    output cfg_upd_o,
    output shift_cnt_o,
    output frame_o,
    output busy_o
  );

  modport master (
    output te_i,
    output scan_clk_i,
    output scan_di_i,
    output status_i,
    input  scan_do_o,
    input  cfg_o,
    input  cfg_upd_o,
    input  shift_cnt_o,
    input  frame_o,
    input  busy_o
  );
endinterface

// File: rtl/toysram_scan_ctl.sv
// Scan controller: synchronises pad TE/SCAN_CLK/SCAN_IN into wb_clk_i,
// captures status on TE rise, shifts on SCAN_CLK rise, updates cfg on TE fall.
module toysram_scan_ctl #(
  parameter int unsigned  W           = 128,
  parameter int unsigned  SYNC_STAGES = 2,
  parameter logic [W-1:0] RESET_VAL   = '0
) (
  input logic               wb_clk_i,
  input logic               wb_rst_i,
  toysram_scan_ctl_if.slave bus
);
  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SHIFT,
    UPDATE
  } state_t;

  state_t state_q;

  logic [SYNC_STAGES-1:0] te_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic te_d1_q;
  logic sclk_d1_q;

  logic te_s;
  logic sclk_s;
  logic sdi_s;
  logic te_rise;
  logic te_fall;
  logic sclk_rise;

  logic [W-1:0]  scan_reg_q;
  logic [W-1:0]  scan_reg_d;
  logic [W-1:0]  cfg_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wrap_d;
  logic          cfg_upd_q;
  logic          frame_q;
  logic          busy_q;

  assign te_s   = te_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync_q[SYNC_STAGES-1];

  assign te_rise   = te_s & ~te_d1_q;
  assign te_fall   = ~te_s & te_d1_q;
  assign sclk_rise = sclk_s & ~sclk_d1_q;

  // Data sync has the same depth as the clock sync, so sdi_s is aligned with sclk_rise.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      te_sync_q   <= '0;
      sclk_sync_q <= '0;
      sdi_sync_q  <= '0;
      te_d1_q     <= 1'b0;
      sclk_d1_q   <= 1'b0;
    end else begin
      te_sync_q   <= {te_sync_q[SYNC_STAGES-2:0], bus.te_i};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.scan_clk_i};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], bus.scan_di_i};
      te_d1_q     <= te_s;
      sclk_d1_q   <= sclk_s;
    end
  end

  always_comb begin
    scan_reg_d = {scan_reg_q[W-2:0], sdi_s};
    wrap_d     = (cnt_q == LAST);
    cnt_d      = wrap_d ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      scan_reg_q <= RESET_VAL;
      cfg_q      <= RESET_VAL;
      cnt_q      <= '0;
      cfg_upd_q  <= 1'b0;
      frame_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cfg_upd_q <= 1'b0;
      frame_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (te_rise) begin
            state_q <= CAPTURE;
            busy_q  <= 1'b1;
          end
        end
        CAPTURE: begin
          scan_reg_q <= bus.status_i;
          cnt_q      <= '0;
          state_q    <= te_fall ? UPDATE : SHIFT;
        end
        SHIFT: begin
          // A shift coinciding with TE fall lands before UPDATE samples scan_reg.
          if (sclk_rise) begin
            scan_reg_q <= scan_reg_d;
            cnt_q      <= cnt_d;
            frame_q    <= wrap_d;
          end
          if (te_fall) begin
            state_q <= UPDATE;
          end
        end
        UPDATE: begin
          cfg_q     <= scan_reg_q;
          cfg_upd_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.scan_do_o   = scan_reg_q[W-1];
  assign bus.cfg_o       = cfg_q;
  assign bus.cfg_upd_o   = cfg_upd_q;
  assign bus.shift_cnt_o = cnt_q;
  assign bus.frame_o     = frame_q;
  assign bus.busy_o      = busy_q;
endmodule
